// File: rtl/var_delay.sv
// Runtime-programmable delay line with valid gating and fill tracking.
// Optional VAR_DELAY_SHRINK_KEEP_EN: shrinking the delay while ready keeps the current epoch.
module var_delay #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MAX_DEL = 16,
  parameter int unsigned DEF_DEL = 1,
  localparam int unsigned DW     = $clog2(MAX_DEL + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic [WIDTH-1:0] din,
  input  logic             din_vld,
  input  logic [DW-1:0]    del_cfg,
  input  logic             del_load,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  output logic [DW-1:0]    del_cur,
  output logic             ready,
  output logic             cfg_err
);

  localparam int unsigned AW = $clog2(MAX_DEL);

  typedef enum logic {StFill, StRun} state_e;

  state_e           state_q;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_nxt, rd_idx;
  logic [DW-1:0]    fill_cnt_q, del_cur_q, d_eff;
  logic [WIDTH-1:0] dout_q;
  logic             dout_vld_q, cfg_err_q;
  logic             clamp, fill_ok, keep, restart;
  logic [WIDTH:0]   rd_entry;
  int unsigned      rd_sum;

  // Buffer is never reset; fill_cnt gating hides stale contents.
  logic [WIDTH:0]   mem [MAX_DEL];

  always_ff @(posedge clk) begin
    if (rst_n && ce) mem[wr_ptr_q] <= {din_vld, din};
  end

  always_comb begin
    wr_ptr_nxt = (wr_ptr_q == AW'(MAX_DEL - 1)) ? '0 : wr_ptr_q + 1'b1;
    // Offset by MAX_DEL so the subtraction never goes negative.
    rd_sum = 32'(wr_ptr_q) + MAX_DEL + 1 - 32'(del_cur_q);
    if (rd_sum >= MAX_DEL) rd_sum = rd_sum - MAX_DEL;
    rd_idx   = AW'(rd_sum);
    rd_entry = (del_cur_q == DW'(1)) ? {din_vld, din} : mem[rd_idx];
    fill_ok  = fill_cnt_q >= (del_cur_q - DW'(1));

    clamp = (del_cfg == '0) || (del_cfg > DW'(MAX_DEL));
    if (del_cfg == '0)                 d_eff = DW'(1);
    else if (del_cfg > DW'(MAX_DEL))   d_eff = DW'(MAX_DEL);
    else                               d_eff = del_cfg;

`ifdef VAR_DELAY_SHRINK_KEEP_EN
    keep = (state_q == StRun) && (d_eff <= del_cur_q);
`else
    keep = 1'b0;
`endif
    restart = del_load && !keep;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StFill;
      wr_ptr_q   <= '0;
      fill_cnt_q <= '0;
      del_cur_q  <= DW'(DEF_DEL);
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      cfg_err_q <= 1'b0;
      if (ce) begin
        wr_ptr_q   <= wr_ptr_nxt;
        if (fill_cnt_q != DW'(MAX_DEL)) fill_cnt_q <= fill_cnt_q + DW'(1);
        dout_q     <= rd_entry[WIDTH-1:0];
        dout_vld_q <= rd_entry[WIDTH] && fill_ok && !restart;
        if (fill_ok) state_q <= StRun;
      end
      // A one-cycle delay needs no history, so it is ready immediately.
      if (del_cur_q == DW'(1)) state_q <= StRun;
      if (del_load) begin
        del_cur_q <= d_eff;
        cfg_err_q <= clamp;
        if (restart) begin
          fill_cnt_q <= '0;
          state_q    <= StFill;
        end
      end
    end
  end

  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;
  assign del_cur  = del_cur_q;
  assign ready    = (state_q == StRun);
  assign cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_var_delay.sv
// Bench for var_delay: sample-history model checked every cycle plus directed literal checks.
module tb_var_delay;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned MAX_DEL = 16;
  localparam int unsigned DEF_DEL = 1;
  localparam int unsigned DW      = $clog2(MAX_DEL + 1);

  logic             clk = 1'b0;
  logic             rst_n, ce, din_vld, del_load;
  logic [WIDTH-1:0] din;
  logic [DW-1:0]    del_cfg;
  logic [WIDTH-1:0] dout;
  logic             dout_vld, ready, cfg_err;
  logic [DW-1:0]    del_cur;

  int n_vec = 0;
  int n_err = 0;

  var_delay #(.WIDTH(WIDTH), .MAX_DEL(MAX_DEL), .DEF_DEL(DEF_DEL)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ce       (ce),
    .din      (din),
    .din_vld  (din_vld),
    .del_cfg  (del_cfg),
    .del_load (del_load),
    .dout     (dout),
    .dout_vld (dout_vld),
    .del_cur  (del_cur),
    .ready    (ready),
    .cfg_err  (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: every written sample kept in order; the output is whatever was written D-1 writes ago.
  logic [WIDTH:0]   hist [$];
  int               m_cnt, m_del, m_eff;
  logic             m_vld, m_known, m_run, m_err, m_keep, m_restart, m_have, m_new_run;
  logic [WIDTH-1:0] m_dout;
  logic [WIDTH:0]   m_e;
  logic             started = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      hist.delete();
      m_cnt = 0; m_del = DEF_DEL; m_vld = 0; m_dout = '0; m_known = 1;
      m_run = 0; m_err = 0; started = 1'b1;
    end else begin
      m_eff = (del_cfg == 0) ? 1 : (int'(del_cfg) > MAX_DEL) ? MAX_DEL : int'(del_cfg);
      m_keep = 1'b0;
`ifdef VAR_DELAY_SHRINK_KEEP_EN
      m_keep = del_load && m_run && (m_eff <= m_del);
`endif
      m_restart = del_load && !m_keep;
      if (ce) begin
        m_have = 1'b1;
        m_e    = '0;
        if (m_del == 1) m_e = {din_vld, din};
        else if (hist.size() >= m_del - 1) m_e = hist[hist.size() - (m_del - 1)];
        else m_have = 1'b0;
        m_dout  = m_e[WIDTH-1:0];
        m_known = m_have;
        m_vld   = m_have && m_e[WIDTH] && (m_cnt >= m_del - 1) && !m_restart;
      end
      if (m_restart) m_new_run = 1'b0;
      else if (m_del == 1 || (ce && m_cnt >= m_del - 1)) m_new_run = 1'b1;
      else m_new_run = m_run;
      if (ce) begin
        hist.push_back({din_vld, din});
        if (hist.size() > 64) void'(hist.pop_front());
        m_cnt++;
      end
      m_err = del_load && (del_cfg == 0 || int'(del_cfg) > MAX_DEL);
      if (del_load) m_del = m_eff;
      if (m_restart) m_cnt = 0;
      m_run = m_new_run;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("dout_vld", 32'(dout_vld), 32'(m_vld));
      if (m_known) check("dout", 32'(dout), 32'(m_dout));
      check("del_cur", 32'(del_cur), 32'(m_del));
      check("ready", 32'(ready), 32'(m_run));
      check("cfg_err", 32'(cfg_err), 32'(m_err));
    end
  end

  task automatic step(input logic c, input logic [WIDTH-1:0] d, input logic v,
                      input logic l, input logic [DW-1:0] cfg);
    ce = c; din = d; din_vld = v; del_load = l; del_cfg = cfg;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; ce = 1'b1; din = '0; din_vld = 1'b0; del_load = 1'b0; del_cfg = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst_dout", 32'(dout), 32'h0);
    check("rst_vld", 32'(dout_vld), 32'h0);
    check("rst_del_cur", 32'(del_cur), 32'd1);
    check("rst_ready", 32'(ready), 32'h0);
    check("rst_cfg_err", 32'(cfg_err), 32'h0);
    rst_n = 1'b1;

    // D=1 ramp
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(i), 1'b1, 1'b0, '0);
      if (i == 0) begin
        check("d1_ready", 32'(ready), 32'h1);
        check("d1_first_vld", 32'(dout_vld), 32'h1);
      end
      if (i == 3) check("d1_dout3", 32'(dout), 32'h03);
    end

    // D=5
    step(1'b1, 8'hFF, 1'b1, 1'b1, 5'd5);
    check("d5_load_vld", 32'(dout_vld), 32'h0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 8'(8'hA0 + i), 1'b1, 1'b0, '0);
      if (i < 4) check("d5_fill_vld", 32'(dout_vld), 32'h0);
      if (i == 4) begin
        check("d5_dout", 32'(dout), 32'hA0);
        check("d5_ready", 32'(ready), 32'h1);
      end
    end

    // D=MAX_DEL across two wraps
    step(1'b1, 8'h00, 1'b1, 1'b1, 5'd16);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 8'(8'h40 + i), 1'b1, 1'b0, '0);
      if (i == 15) check("d16_first", 32'(dout), 32'h40);
      if (i == 39) check("d16_last", 32'(dout), 32'h58);
    end

    // Clamping
    step(1'b1, 8'h01, 1'b1, 1'b1, 5'd0);
    check("clamp0_del", 32'(del_cur), 32'd1);
    check("clamp0_err", 32'(cfg_err), 32'h1);
    step(1'b1, 8'h02, 1'b1, 1'b0, '0);
    check("clamp_err_pulse", 32'(cfg_err), 32'h0);
    step(1'b1, 8'h03, 1'b1, 1'b1, 5'd20);
    check("clamp20_del", 32'(del_cur), 32'd16);
    check("clamp20_err", 32'(cfg_err), 32'h1);

    // D=4 with ce toggling, then a mid-stream reset
    step(1'b1, 8'h00, 1'b1, 1'b1, 5'd4);
    check("d4_noclamp_err", 32'(cfg_err), 32'h0);
    for (int i = 0; i < 20; i++) begin
      step(1'((i % 2) == 0), 8'(8'h10 + i), 1'b1, 1'b0, '0);
      if (i == 6) check("d4_emerge", 32'(dout), 32'h10);
      if (i == 7) check("d4_hold", 32'(dout), 32'h10);
    end
    rst_n = 1'b0;
    step(1'b1, 8'h55, 1'b1, 1'b0, '0);
    rst_n = 1'b1;
    check("mid_rst_dout", 32'(dout), 32'h0);
    check("mid_rst_vld", 32'(dout_vld), 32'h0);
    check("mid_rst_del", 32'(del_cur), 32'd1);

    // Shrink from 8 to 3 while running
    step(1'b1, 8'h00, 1'b1, 1'b1, 5'd8);
    for (int i = 0; i < 12; i++) step(1'b1, 8'(8'h60 + i), 1'b1, 1'b0, '0);
    step(1'b1, 8'h6C, 1'b1, 1'b1, 5'd3);
`ifdef VAR_DELAY_SHRINK_KEEP_EN
    check("shrink_ready", 32'(ready), 32'h1);
    step(1'b1, 8'h6D, 1'b1, 1'b0, '0);
    check("shrink_jump", 32'(dout), 32'h6B);
`else
    check("shrink_ready", 32'(ready), 32'h0);
    step(1'b1, 8'h6D, 1'b1, 1'b0, '0);
    check("shrink_fill_vld", 32'(dout_vld), 32'h0);
`endif
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h6E + i), 1'b1, 1'b0, '0);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 7) != 0),
           1'($urandom_range(0, 19) == 0), 5'($urandom_range(0, 20)));
    end
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
